// File: rtl/usart_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : usart_rx_deframer_if
// Purpose  : Bundles the RX-FIFO pop port and the payload/status stream of
//            the usart RX deframer. The master side is the deframer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface usart_rx_deframer_if;
  logic [7:0] rx_data_out;
  logic       rx_empty;
  logic       rx_read_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    input  rx_data_out, rx_empty, out_ready,
    output rx_read_en, out_data, out_valid, out_last,
           frame_done, frame_err, err_code
  );

  modport slave (
    output rx_data_out, rx_empty, out_ready,
    input  rx_read_en, out_data, out_valid, out_last,
           frame_done, frame_err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/usart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : usart_rx_deframer
// Purpose  : Pops bytes from the usart RX FIFO, hunts for SOF, parses
//            length/payload/checksum and streams payload on valid/ready.
//            Each frame attempt ends with a one-cycle frame_done pulse.
// Options  : DEFRAMER_TIMEOUT_EN - abort a frame after TIMEOUT_CYCLES idle
//            cycles inside the frame (err_code 11).
// Revision : 1.0 - initial release
// ============================================================================
module usart_rx_deframer #(
  parameter logic [7:0] SOF_BYTE       = 8'h7E,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  usart_rx_deframer_if.master bus
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_OK   = 2'b00;
  localparam logic [1:0] c_ERR_CSUM = 2'b01;
  localparam logic [1:0] c_ERR_LEN  = 2'b10;
  localparam logic [7:0] c_MAX_LEN  = 8'(MAX_LEN);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_rd_pend;
  logic [7:0] r_sum;
  logic [7:0] r_cnt;
  logic [7:0] r_out_data;
  logic       r_out_valid;
  logic       r_out_last;
  logic       r_done;
  logic       r_err;
  logic [1:0] r_code;

  logic       w_land;
  logic       w_out_free;
  logic       w_rd_en;
  logic       w_load;
  logic       w_last;
  logic       w_done;
  logic       w_err;
  logic [1:0] w_code;
  logic [7:0] w_byte;
  logic [7:0] w_sum_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_csum;

  // A byte is on rx_data_out exactly one cycle after its pop was issued.
  assign w_land     = r_rd_pend;
  assign w_byte     = bus.rx_data_out;
  assign w_out_free = !r_out_valid || bus.out_ready;
  // Only pop when the output register can take a payload byte next cycle.
  assign w_rd_en    = !rst && !bus.rx_empty && !r_rd_pend && w_out_free;
  assign w_csum     = r_sum + w_byte;

`ifdef DEFRAMER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TO_W-1:0] r_to_cnt;
  logic              w_to_wait;
  logic              w_to_hit;

  // Waiting inside a frame for a byte, not blocked by downstream.
  assign w_to_wait = (r_state != ST_HUNT) && !w_land && w_out_free;
  assign w_to_hit  = w_to_wait && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, cleared by every landed byte.
  always_ff @(posedge clk) begin
    if (rst || w_land || (r_state == ST_HUNT) || w_to_hit) begin
      r_to_cnt <= '0;
    end else if (w_to_wait) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, field accumulation and status decisions for a landed byte.
  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_last      = 1'b0;
    w_done      = 1'b0;
    w_err       = r_err;
    w_code      = r_code;
    case (r_state)
      ST_HUNT: begin
        if (w_land && (w_byte == SOF_BYTE)) begin
          w_state_nxt = ST_LEN;
          w_sum_nxt   = 8'd0;
        end
      end
      ST_LEN: begin
        if (w_land) begin
          w_sum_nxt = w_byte;
          w_cnt_nxt = w_byte;
          if (w_byte > c_MAX_LEN) begin
            w_done      = 1'b1;
            w_err       = 1'b1;
            w_code      = c_ERR_LEN;
            w_state_nxt = ST_HUNT;
          end else if (w_byte == 8'd0) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_land) begin
          w_load    = 1'b1;
          w_sum_nxt = w_csum;
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_last      = 1'b1;
            w_state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_land) begin
          w_done      = 1'b1;
          w_err       = (w_csum != 8'd0);
          w_code      = (w_csum == 8'd0) ? c_ERR_OK : c_ERR_CSUM;
          w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
`ifdef DEFRAMER_TIMEOUT_EN
    if (w_to_hit) begin
      w_done      = 1'b1;
      w_err       = 1'b1;
      w_code      = 2'b11;
      w_state_nxt = ST_HUNT;
    end
`endif
  end

  // Datapath: outstanding-read flag, running sum/count and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_sum     <= 8'd0;
      r_cnt     <= 8'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= c_ERR_OK;
    end else begin
      r_rd_pend <= w_rd_en;
      r_sum     <= w_sum_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_code    <= w_code;
    end
  end

  // Payload output register: load on a landed payload byte, drop on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_byte;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign bus.rx_read_en = w_rd_en;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign bus.err_code   = r_code;

endmodule
`default_nettype wire

// File: doc/usart_rx_deframer.md
Name: usart_rx_deframer

Overview:
Downstream consumer of the usart RX FIFO. It pops received bytes through the rx_read_en / rx_empty / rx_data_out interface and hunts for a start-of-frame byte. It parses length, payload and checksum fields and streams payload bytes out on a valid/ready interface. Each frame ends with a one-cycle pass/fail status pulse; this is the first protocol layer above the serial link.

Parameters:
SOF_BYTE, 8'h7E, start-of-frame delimiter.
MAX_LEN, 16, largest legal payload length in bytes (1..255).
TIMEOUT_CYCLES, 1024, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous, active-high reset.
rx_data_out  input  8  byte from usart RX FIFO; valid the cycle after rx_read_en is sampled high.
rx_empty  input  1  usart RX FIFO empty.
rx_read_en  output  1  pop request to usart RX FIFO, one-cycle pulse.
out_data  output  8  payload byte.
out_valid  output  1  out_data valid; held until accepted.
out_ready  input  1  downstream accepts out_data when out_valid & out_ready.
out_last  output  1  qualifies the final payload byte of a frame.
frame_done  output  1  one-cycle pulse at end of every frame attempt, good or bad.
frame_err  output  1  registered with frame_done; 1 = frame rejected.
err_code  output  2  00 ok, 01 checksum, 10 length, 11 timeout; held until next frame_done.

Behaviour:
- Reset, applied any cycle including mid-frame:
  - state=HUNT; rx_read_en=0, out_valid=0, out_last=0, out_data=0, frame_done=0, frame_err=0, err_code=00.
  - Running sum, byte counter and outstanding-read flag are cleared.
  - Partial frames are discarded with no frame_done.
- Fetch rule: rx_read_en=1 when all of the following hold:
  - !rx_empty;
  - no read is outstanding (a pop issued last cycle whose byte has not yet landed);
  - the output register is free: !out_valid, or out_valid & out_ready in that cycle.
- Each pop yields exactly one byte the following cycle, so throughput is at most one byte per 2 cycles. Reads are never issued while out_valid is stalled.
- HUNT state:
  - Byte == SOF_BYTE -> LEN; sum is cleared.
  - Any other byte is dropped silently, with no status pulse.
- LEN state: byte L is captured; sum = L; count = L.
  - L > MAX_LEN -> frame_done=1, frame_err=1, err_code=10, next state HUNT.
  - L == 0 -> CSUM.
  - Otherwise -> PAYLOAD.
- PAYLOAD state, for each byte:
  - The byte is loaded into out_data with out_valid=1; sum += byte (mod 256); count decrements.
  - out_last=1 on the byte where count reaches 0, then next state is CSUM.
  - Payload is forwarded before the checksum is known; downstream uses frame_err to discard.
- CSUM state: byte C arrives.
  - (sum + C) mod 256 == 0 -> frame_done=1, frame_err=0, err_code=00.
  - Otherwise -> frame_done=1, frame_err=1, err_code=01.
  - Next state is HUNT.
- frame_done is asserted exactly one cycle after the checksum byte lands (registered). It may coincide with out_valid still holding the last payload byte.
- A SOF_BYTE value inside LEN, PAYLOAD or CSUM is treated as data, with no resync.
- out_data, out_last: stable while out_valid & !out_ready. out_last clears when its byte is accepted.
- An empty FIFO mid-frame simply stalls the parser, with no error, unless the optional feature is enabled.

Optional Feature:
DEFRAMER_TIMEOUT_EN
- Defined:
  - A counter resets on every landed byte and increments each cycle in LEN, PAYLOAD or CSUM while waiting for a byte.
  - The counter does not increment while stalled on out_valid & !out_ready.
  - On reaching TIMEOUT_CYCLES -> frame_done=1, frame_err=1, err_code=11, state=HUNT.
  - A pending out_valid byte is still delivered.
- Undefined: no counter logic exists, err_code 11 is never produced, and the parser waits indefinitely.

Test Plan:
- Good frame: FIFO holds 7E 03 A5 3C F0 2C, out_ready=1 -> out_data A5, 3C, F0 with out_last on F0; frame_done with frame_err=0, err_code=00; exactly 6 rx_read_en pulses.
- Hunt: bytes 00 11 7E 01 99 66 -> 00 and 11 dropped with no frame_done; single payload 99 with out_last=1; frame passes.
- Checksum/length errors: 7E 02 12 34 00 -> 12, 34 delivered, then frame_err=1, err_code=01. Next, 7E 11 -> immediate frame_done, err_code=10, no out_valid.
- Zero length plus backpressure:
  - 7E 00 00 -> frame_done ok, out_valid never asserted.
  - Good frame with out_ready=0 for 20 cycles on 3C -> out_data stays 3C, no rx_read_en during the stall, no byte lost.
- Reset mid-frame: rst for 1 cycle after 7E 03 A5 -> all outputs at reset values, no frame_done. A following 7E 01 99 66 is parsed correctly.
- With DEFRAMER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 7E 03 A5 then silence -> err_code=11 after 16 idle cycles. Without the macro: no frame_done.
